// File: rtl/gpu_pkg.sv
// Shared constants and FSM encoding for the column buffer.
// Imported by column_buffer_ctrl.
package gpu_pkg;

  localparam int COLUMNS = 320;
  localparam int IDX_W   = 9;
  localparam int DATA_W  = 16;

  localparam logic [15:0] CLEAR_DISTANCE = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    SWAP    = 2'd2,
    CLEAR   = 2'd3
  } state_e;

endpackage

// File: rtl/column_bank.sv
// One column bank: simple dual-port RAM, registered read.
// Ports: we/wr_addr/wr_data write, rd_addr -> rd_data one cycle later.
module column_bank #(
  parameter int DEPTH = 320,
  parameter int AW    = 9,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/column_buffer_ctrl.sv
// Double-buffered column store: CPU fills back bank, GPU reads front.
// Ports: cpu_wr_* write handshake, swap_req/frame_start, gpu_* read, status.
module column_buffer_ctrl #(
  parameter int          COLUMNS        = gpu_pkg::COLUMNS,
  parameter int          IDX_W          = gpu_pkg::IDX_W,
  parameter int          DATA_W         = gpu_pkg::DATA_W,
  parameter int          CLEAR_ON_SWAP  = 1,
  parameter logic [15:0] CLEAR_DISTANCE = gpu_pkg::CLEAR_DISTANCE
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              cpu_wr_valid,
  output logic              cpu_wr_ready,
  input  logic [IDX_W-1:0]  cpu_wr_index,
  input  logic [DATA_W-1:0] cpu_wr_distance,
  input  logic [DATA_W-1:0] cpu_wr_texture,
  input  logic              swap_req,
  input  logic              frame_start,
  input  logic [IDX_W-1:0]  gpu_read_index,
  output logic [DATA_W-1:0] gpu_distance,
  output logic [DATA_W-1:0] gpu_texture,
  output logic              buffer_select,
  output logic              swap_pending,
  output logic              swap_ack,
  output logic              oob_error
);
  import gpu_pkg::*;

  localparam int CW = 2 * DATA_W;
  localparam logic [IDX_W:0]   NCOL = (IDX_W+1)'(COLUMNS);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(COLUMNS - 1);

  state_e           state_q, state_d;
  logic             sel_q, sel_d;
  logic             oob_q, oob_d;
  logic             latch_q, latch_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             rd_sel_q, rd_zero_q;

  logic             wr_ok, rd_ok, rdy;
  logic             we;
  logic [IDX_W-1:0] waddr;
  logic [CW-1:0]    wdata;
  logic [CW-1:0]    q0, q1, rdata;

  assign wr_ok = {1'b0, cpu_wr_index} < NCOL;
  assign rd_ok = {1'b0, gpu_read_index} < NCOL;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    oob_d   = oob_q;
    latch_d = latch_q;
    cnt_d   = cnt_q;
    rdy     = 1'b0;
    we      = 1'b0;
    waddr   = cpu_wr_index;
    wdata   = {cpu_wr_distance, cpu_wr_texture};
    unique case (state_q)
      IDLE: begin
        rdy = 1'b1;
        if (cpu_wr_valid) begin
          if (wr_ok) we = 1'b1;
          else oob_d = 1'b1;
        end
        if (swap_req)
          state_d = frame_start ? SWAP : PENDING;
      end
      PENDING: begin
        if (frame_start) state_d = SWAP;
      end
      SWAP: begin
        sel_d = ~sel_q;
        if (CLEAR_ON_SWAP != 0) begin
          state_d = CLEAR;
          cnt_d   = '0;
          latch_d = latch_q | swap_req;
        end else begin
          state_d = (latch_q | swap_req) ? PENDING : IDLE;
          latch_d = 1'b0;
        end
      end
      CLEAR: begin
        we    = 1'b1;
        waddr = cnt_q;
        wdata = {CLEAR_DISTANCE[DATA_W-1:0], {DATA_W{1'b0}}};
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          latch_d = 1'b0;
          state_d = (latch_q | swap_req) ? PENDING : IDLE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          latch_d = latch_q | swap_req;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= IDLE;
      sel_q     <= 1'b0;
      oob_q     <= 1'b0;
      latch_q   <= 1'b0;
      cnt_q     <= '0;
      rd_sel_q  <= 1'b0;
      rd_zero_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      oob_q     <= oob_d;
      latch_q   <= latch_d;
      cnt_q     <= cnt_d;
      // bank choice travels with the sampled index
      rd_sel_q  <= sel_q;
      rd_zero_q <= ~rd_ok;
    end
  end

  column_bank #(.DEPTH(COLUMNS), .AW(IDX_W), .DW(CW)) u_bank0 (
    .clk     (clk),
    .we      (we & sel_q),
    .wr_addr (waddr),
    .wr_data (wdata),
    .rd_addr (gpu_read_index),
    .rd_data (q0)
  );

  column_bank #(.DEPTH(COLUMNS), .AW(IDX_W), .DW(CW)) u_bank1 (
    .clk     (clk),
    .we      (we & ~sel_q),
    .wr_addr (waddr),
    .wr_data (wdata),
    .rd_addr (gpu_read_index),
    .rd_data (q1)
  );

  always_comb begin
    rdata = rd_sel_q ? q1 : q0;
    if (rd_zero_q) rdata = '0;
  end

  assign gpu_distance  = rdata[CW-1:DATA_W];
  assign gpu_texture   = rdata[DATA_W-1:0];
  assign cpu_wr_ready  = rdy & ~clr;
  assign buffer_select = sel_q;
  assign swap_pending  = (state_q == PENDING);
  assign swap_ack      = (state_q == SWAP);
  assign oob_error     = oob_q;

endmodule

// File: tb/tb_column_buffer_ctrl.sv
// Directed bench for column_buffer_ctrl.
// Reports one summary line with error and check counts.
module tb_column_buffer_ctrl;

  logic        clk = 1'b0;
  logic        clr;
  logic        cpu_wr_valid;
  logic        cpu_wr_ready;
  logic [8:0]  cpu_wr_index;
  logic [15:0] cpu_wr_distance;
  logic [15:0] cpu_wr_texture;
  logic        swap_req;
  logic        frame_start;
  logic [8:0]  gpu_read_index;
  logic [15:0] gpu_distance;
  logic [15:0] gpu_texture;
  logic        buffer_select;
  logic        swap_pending;
  logic        swap_ack;
  logic        oob_error;

  int errors = 0;
  int checks = 0;
  int since_swap;

  column_buffer_ctrl dut (
    .clk             (clk),
    .clr             (clr),
    .cpu_wr_valid    (cpu_wr_valid),
    .cpu_wr_ready    (cpu_wr_ready),
    .cpu_wr_index    (cpu_wr_index),
    .cpu_wr_distance (cpu_wr_distance),
    .cpu_wr_texture  (cpu_wr_texture),
    .swap_req        (swap_req),
    .frame_start     (frame_start),
    .gpu_read_index  (gpu_read_index),
    .gpu_distance    (gpu_distance),
    .gpu_texture     (gpu_texture),
    .buffer_select   (buffer_select),
    .swap_pending    (swap_pending),
    .swap_ack        (swap_ack),
    .oob_error       (oob_error)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr = 1'b1;
    cpu_wr_valid = 1'b0;
    cpu_wr_index = '0;
    cpu_wr_distance = '0;
    cpu_wr_texture = '0;
    swap_req = 1'b0;
    frame_start = 1'b0;
    gpu_read_index = '0;
    tick();
    tick();
    checks++;
    if (cpu_wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_ready: got %b want 0", cpu_wr_ready);
    end
    checks++;
    if ({buffer_select, swap_pending, swap_ack, oob_error} !== 4'b0) begin
      errors++;
      $display("FAIL rst_flags: got %b want 0000",
               {buffer_select, swap_pending, swap_ack, oob_error});
    end
    checks++;
    if ({gpu_distance, gpu_texture} !== 32'h0) begin
      errors++;
      $display("FAIL rst_data: got %h want 0", {gpu_distance, gpu_texture});
    end
    clr = 1'b0;
    #1;
    checks++;
    if (cpu_wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_ready_after: got %b want 1", cpu_wr_ready);
    end
  endtask

  task automatic test_write_swap();
    int early;
    cpu_wr_valid = 1'b1;
    cpu_wr_index = 9'd5;
    cpu_wr_distance = 16'h0123;
    cpu_wr_texture = 16'h0007;
    tick();
    cpu_wr_valid = 1'b0;
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    checks++;
    if ({swap_pending, cpu_wr_ready} !== 2'b10) begin
      errors++;
      $display("FAIL pend_state: got pend/rdy %b want 10",
               {swap_pending, cpu_wr_ready});
    end
    early = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (swap_ack === 1'b1) early++;
    end
    checks++;
    if (early !== 0) begin
      errors++;
      $display("FAIL early_ack: got %0d acks want 0", early);
    end
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    since_swap = 0;
    checks++;
    if (swap_ack !== 1'b1) begin
      errors++;
      $display("FAIL swap_ack1: got %b want 1", swap_ack);
    end
    tick();
    since_swap++;
    checks++;
    if (buffer_select !== 1'b1) begin
      errors++;
      $display("FAIL bufsel1: got %b want 1", buffer_select);
    end
    gpu_read_index = 9'd5;
    tick();
    since_swap++;
    checks++;
    if ({gpu_distance, gpu_texture} !== 32'h0123_0007) begin
      errors++;
      $display("FAIL read5: got %h want 01230007",
               {gpu_distance, gpu_texture});
    end
  endtask

  task automatic test_clear();
    int pend_seen;
    pend_seen = 0;
    while (cpu_wr_ready !== 1'b1 && since_swap < 400) begin
      tick();
      since_swap++;
      if (swap_pending === 1'b1) pend_seen++;
    end
    checks++;
    if (since_swap !== 321) begin
      errors++;
      $display("FAIL clear_len: got idle at %0d want 321", since_swap);
    end
    checks++;
    if (pend_seen !== 0) begin
      errors++;
      $display("FAIL clear_pend: got %0d pending cycles want 0", pend_seen);
    end
  endtask

  task automatic test_coincident();
    cpu_wr_valid = 1'b1;
    cpu_wr_index = 9'd7;
    cpu_wr_distance = 16'h1111;
    cpu_wr_texture = 16'h2222;
    swap_req = 1'b1;
    frame_start = 1'b1;
    tick();
    cpu_wr_valid = 1'b0;
    swap_req = 1'b0;
    frame_start = 1'b0;
    since_swap = 0;
    checks++;
    if ({swap_ack, swap_pending} !== 2'b10) begin
      errors++;
      $display("FAIL coinc_ack: got ack/pend %b want 10",
               {swap_ack, swap_pending});
    end
    gpu_read_index = 9'd5;
    tick();
    since_swap++;
    checks++;
    if ({gpu_distance, gpu_texture} !== 32'h0123_0007) begin
      errors++;
      $display("FAIL old_front: got %h want 01230007",
               {gpu_distance, gpu_texture});
    end
    checks++;
    if ({buffer_select, swap_pending} !== 2'b00) begin
      errors++;
      $display("FAIL coinc_sel: got sel/pend %b want 00",
               {buffer_select, swap_pending});
    end
    gpu_read_index = 9'd200;
    tick();
    since_swap++;
    checks++;
    if ({gpu_distance, gpu_texture} !== 32'hFFFF_0000) begin
      errors++;
      $display("FAIL read200: got %h want ffff0000",
               {gpu_distance, gpu_texture});
    end
    gpu_read_index = 9'd7;
    tick();
    since_swap++;
    checks++;
    if ({gpu_distance, gpu_texture} !== 32'h1111_2222) begin
      errors++;
      $display("FAIL read7: got %h want 11112222",
               {gpu_distance, gpu_texture});
    end
  endtask

  task automatic test_req_during_clear();
    int acks;
    swap_req = 1'b1;
    tick();
    since_swap++;
    swap_req = 1'b0;
    while (swap_pending !== 1'b1 && cpu_wr_ready !== 1'b1
           && since_swap < 400) begin
      tick();
      since_swap++;
    end
    checks++;
    if ({swap_pending, cpu_wr_ready} !== 2'b10 || since_swap !== 321) begin
      errors++;
      $display("FAIL latch_pend: got pend/rdy %b at %0d want 10 at 321",
               {swap_pending, cpu_wr_ready}, since_swap);
    end
    acks = 0;
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    if (swap_ack === 1'b1) acks++;
    for (int i = 0; i < 330; i++) begin
      tick();
      if (swap_ack === 1'b1) acks++;
    end
    checks++;
    if (acks !== 1) begin
      errors++;
      $display("FAIL one_ack: got %0d acks want 1", acks);
    end
    checks++;
    if ({cpu_wr_ready, swap_pending, buffer_select} !== 3'b101) begin
      errors++;
      $display("FAIL after_dbl: got rdy/pend/sel %b want 101",
               {cpu_wr_ready, swap_pending, buffer_select});
    end
  endtask

  task automatic test_oob();
    cpu_wr_valid = 1'b1;
    cpu_wr_index = 9'd320;
    cpu_wr_distance = 16'hDEAD;
    cpu_wr_texture = 16'hBEEF;
    tick();
    cpu_wr_valid = 1'b0;
    checks++;
    if ({oob_error, cpu_wr_ready} !== 2'b11) begin
      errors++;
      $display("FAIL oob_flag: got oob/rdy %b want 11",
               {oob_error, cpu_wr_ready});
    end
    gpu_read_index = 9'd400;
    tick();
    checks++;
    if ({gpu_distance, gpu_texture} !== 32'h0) begin
      errors++;
      $display("FAIL read400: got %h want 0", {gpu_distance, gpu_texture});
    end
    gpu_read_index = 9'd319;
    tick();
    checks++;
    if ({gpu_distance, gpu_texture} !== 32'hFFFF_0000) begin
      errors++;
      $display("FAIL read319: got %h want ffff0000",
               {gpu_distance, gpu_texture});
    end
    gpu_read_index = 9'd5;
    tick();
    checks++;
    if ({gpu_distance, gpu_texture} !== 32'hFFFF_0000) begin
      errors++;
      $display("FAIL read5_clr: got %h want ffff0000",
               {gpu_distance, gpu_texture});
    end
  endtask

  task automatic test_clr_pending();
    int acks;
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    checks++;
    if (swap_pending !== 1'b1) begin
      errors++;
      $display("FAIL clr_pre: got pend %b want 1", swap_pending);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    #1;
    checks++;
    if ({cpu_wr_ready, swap_pending, buffer_select, oob_error} !== 4'b1000)
    begin
      errors++;
      $display("FAIL clr_state: got rdy/pend/sel/oob %b want 1000",
               {cpu_wr_ready, swap_pending, buffer_select, oob_error});
    end
    acks = 0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (swap_ack === 1'b1) acks++;
      tick();
    end
    checks++;
    if (acks !== 0) begin
      errors++;
      $display("FAIL clr_drop: got %0d acks want 0", acks);
    end
  endtask

  initial begin
    test_reset();
    test_write_swap();
    test_clear();
    test_coincident();
    test_req_during_clear();
    test_oob();
    test_clr_pending();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
